canvas_painter: RTL
===================

CANVAS_PAINTER -- requirements
Module: canvas_painter

Interface
REQ-001 Parameter ORG_X, default 200, is the DrawX/BallX pixel of canvas cell column 0.
REQ-002 Parameter ORG_Y, default 44, is the BallY pixel of canvas cell row 0.
REQ-003 Parameter CELL, default 14, is the cell edge in pixels; the grid is fixed at 28x28.
REQ-004 Parameter INK, default 16'h07F8, is the centre-cell value; bits [10:3] are all ones, so the cell displays white.
REQ-005 Parameter HALO, default 16'h0400, is the neighbour increment.
REQ-006 Clk  input  1  system clock; all state changes on its rising edge.
REQ-007 Reset  input  1  asynchronous, active-high reset.
REQ-008 BallX, BallY  input  10 each  cursor pixel position.
REQ-009 draw_en  input  1  pen-down level.
REQ-010 frame_tick  input  1  one-cycle strobe, once per frame.
REQ-011 clear_req  input  1  one-cycle strobe requesting a canvas wipe.
REQ-012 canvas  output  16 x [27:0][27:0]  registered cell array, indexed canvas[x][y].
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 clear_done  output  1  one-cycle pulse when a wipe completes.

Function
REQ-015 The FSM SHALL have the states IDLE, MAP, PAINT and CLEAR.
REQ-016 In IDLE, a pending or current clear_req SHALL move the FSM to CLEAR; clear takes priority over frame_tick in the same cycle.
REQ-017 In IDLE, with no clear pending, frame_tick with draw_en=1 SHALL capture BallX and BallY and move the FSM to MAP.
REQ-018 frame_tick with draw_en=0, or frame_tick while busy, SHALL be ignored and not queued.
REQ-019 MAP (1 cycle) SHALL compute cx=floor((BallX-ORG_X)/CELL) and cy=floor((BallY-ORG_Y)/CELL) from the captured values.
REQ-020 MAP SHALL set in_range only when ORG_X<=BallX<ORG_X+28*CELL and ORG_Y<=BallY<ORG_Y+28*CELL.
REQ-021 From MAP, the FSM SHALL go to PAINT if in_range=1, otherwise to IDLE with no write.
REQ-022 PAINT SHALL take exactly 5 cycles, visiting in order: centre, (cx-1,cy), (cx+1,cy), (cx,cy-1), (cx,cy+1), one cell per cycle.
REQ-023 A neighbour outside 0..27 SHALL be skipped: that cycle is still spent, nothing is written, and indices do not wrap.
REQ-024 The centre write SHALL be canvas = INK.
REQ-025 A neighbour write SHALL be canvas = min(canvas + HALO, INK), using 17-bit intermediate arithmetic.
REQ-026 Every write SHALL be visible on canvas the cycle after its PAINT cycle; total latency from frame_tick to the last write is 7 edges.
REQ-027 CLEAR SHALL zero column x (all 28 cells) per cycle, for x=0..27 (28 cycles), then pulse clear_done for one cycle and return to IDLE.
REQ-028 clear_req arriving in MAP, PAINT or CLEAR SHALL set clear_pending; it is serviced on the next IDLE cycle and then cleared.
REQ-029 Multiple clear_req strobes while pending SHALL coalesce into one wipe.
REQ-030 A clear_req arriving during CLEAR SHALL cause exactly one additional wipe.
REQ-031 Cells not addressed in a cycle SHALL hold their value.

Reset
REQ-032 Reset SHALL immediately force: state IDLE, all canvas cells 0, busy=0, clear_done=0, clear_pending=0, and all captured and counter registers 0.
REQ-033 Reset asserted mid-PAINT or mid-CLEAR SHALL abort the operation with no partial writes after its assertion.
REQ-034 The first frame_tick honoured SHALL be the one in the first cycle after Reset deasserts.

Configuration
REQ-035 The macro is CANVAS_HALO_EN.
REQ-036 With CANVAS_HALO_EN defined, PAINT SHALL behave per REQ-022 to REQ-025.
REQ-037 Without CANVAS_HALO_EN, PAINT SHALL be 1 cycle, centre cell only; total latency is 3 edges, and HALO is unused.

Verification
REQ-038 Reset; frame_tick with draw_en=1, BallX=207, BallY=51 -> canvas[0][0]=07F8, canvas[1][0]=0400, canvas[0][1]=0400, no other nonzero cell, busy high for 6 cycles.
REQ-039 Paint twice at BallX=221, BallY=58 (cell 1,1), then once at cell 2,1 -> canvas[2][1]=07F8 and canvas[3][1]=0400.
REQ-039 (cont.) In the same test, canvas[1][1] stays 07F8 (saturated) and canvas[1][0]=07F8 (0400+0400, clamped).
REQ-040 BallX=199 or BallX=592 with draw_en=1 -> MAP then IDLE, canvas unchanged, busy high 1 cycle.
REQ-041 clear_req in the same cycle as frame_tick -> CLEAR runs, the paint is dropped, clear_done pulses 29 cycles later, and all cells are 0.
REQ-042 clear_req during PAINT -> the paint completes, then CLEAR starts the next IDLE cycle.
REQ-043 Reset asserted on the 10th CLEAR cycle -> all cells 0 immediately and busy=0.
REQ-044 Build without CANVAS_HALO_EN -> scenario REQ-038 yields only canvas[0][0]=07F8.

Source files
------------

// File: rtl/canvas_painter_if.sv
// Cursor/strobe inputs and the painted cell array of canvas_painter.
// The master drives the cursor and strobes; the slave (the painter) returns the canvas and status.
interface canvas_painter_if;
   logic [9:0]                  BallX;
   logic [9:0]                  BallY;
   logic                        draw_en;
   logic                        frame_tick;
   logic                        clear_req;
   logic [27:0][27:0][15:0]     canvas;
   logic                        busy;
   logic                        clear_done;

   modport master (
      output BallX, BallY, draw_en, frame_tick, clear_req,
      input  canvas, busy, clear_done
   );

   modport slave (
      input  BallX, BallY, draw_en, frame_tick, clear_req,
      output canvas, busy, clear_done
   );
endinterface

// File: rtl/canvas_painter.sv
// Paints a 28x28 cell canvas at the cursor cell once per frame, and wipes it column by column on request.
// Build option CANVAS_HALO_EN: each paint also brightens the four neighbours of the painted cell.
module canvas_painter #(
   parameter int          ORG_X = 200,
   parameter int          ORG_Y = 44,
   parameter int          CELL  = 14,
   parameter logic [15:0] INK   = 16'h07F8,
   parameter logic [15:0] HALO  = 16'h0400
) (
   input logic             Clk,
   input logic             Reset,
   canvas_painter_if.slave bus
);
   localparam int GRID = 28;

`ifdef CANVAS_HALO_EN
   localparam logic [2:0] LAST_STEP = 3'd4;
`else
   localparam logic [2:0] LAST_STEP = 3'd0;
`endif

   typedef enum logic [1:0] {IDLE, MAP, PAINT, CLEAR} state_t;

   state_t                          state;
   logic [9:0]                      bx_p0, by_p0;
   logic [4:0]                      cx_p1, cy_p1;
   logic [2:0]                      step;
   logic [4:0]                      col;
   logic                            clear_pending;
   logic                            busy_q;
   logic                            clear_done_q;
   logic [GRID-1:0][GRID-1:0][15:0] canvas_q;

   logic signed [11:0]              dx, dy;
   logic                            map_in_range;
   logic [4:0]                      map_cx, map_cy;
   logic                            wr_en, wr_centre;
   logic [4:0]                      wr_x, wr_y;

   function automatic logic [15:0] halo_sat(input logic [15:0] cur);
      logic [16:0] sum;
      sum = {1'b0, cur} + {1'b0, HALO};
      return (sum > {1'b0, INK}) ? INK : sum[15:0];
   endfunction

   // MAP: pixel offsets from the canvas origin; negative means left of / above the canvas
   assign dx = $signed({2'b00, bx_p0}) - $signed(12'(ORG_X));
   assign dy = $signed({2'b00, by_p0}) - $signed(12'(ORG_Y));

   assign map_in_range = (dx >= 12'sd0) && (dx < $signed(12'(GRID * CELL))) &&
                         (dy >= 12'sd0) && (dy < $signed(12'(GRID * CELL)));
   assign map_cx = 5'(dx / $signed(12'(CELL)));
   assign map_cy = 5'(dy / $signed(12'(CELL)));

   // PAINT: one target cell per step; edge neighbours are dropped rather than wrapped
   always_comb begin
      wr_en     = 1'b0;
      wr_centre = 1'b0;
      wr_x      = cx_p1;
      wr_y      = cy_p1;
      if (state == PAINT) begin
         case (step)
            3'd0: begin
               wr_en     = 1'b1;
               wr_centre = 1'b1;
            end
            3'd1: begin
               wr_x  = cx_p1 - 5'd1;
               wr_en = (cx_p1 != 5'd0);
            end
            3'd2: begin
               wr_x  = cx_p1 + 5'd1;
               wr_en = (cx_p1 != 5'd27);
            end
            3'd3: begin
               wr_y  = cy_p1 - 5'd1;
               wr_en = (cy_p1 != 5'd0);
            end
            3'd4: begin
               wr_y  = cy_p1 + 5'd1;
               wr_en = (cy_p1 != 5'd27);
            end
            default: wr_en = 1'b0;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state         <= IDLE;
         bx_p0         <= '0;
         by_p0         <= '0;
         cx_p1         <= '0;
         cy_p1         <= '0;
         step          <= '0;
         col           <= '0;
         clear_pending <= 1'b0;
         busy_q        <= 1'b0;
         clear_done_q  <= 1'b0;
         canvas_q      <= '0;
      end else begin
         clear_done_q <= 1'b0;

         if (wr_en)
            canvas_q[wr_x][wr_y] <= wr_centre ? INK : halo_sat(canvas_q[wr_x][wr_y]);

         // A wipe request seen while busy is remembered once and serviced from IDLE
         if (state != IDLE && bus.clear_req)
            clear_pending <= 1'b1;

         case (state)
            IDLE: begin
               if (clear_pending || bus.clear_req) begin
                  clear_pending <= 1'b0;
                  col           <= '0;
                  busy_q        <= 1'b1;
                  state         <= CLEAR;
               end else if (bus.frame_tick && bus.draw_en) begin
                  bx_p0  <= bus.BallX;
                  by_p0  <= bus.BallY;
                  busy_q <= 1'b1;
                  state  <= MAP;
               end
            end
            MAP: begin
               cx_p1 <= map_cx;
               cy_p1 <= map_cy;
               step  <= '0;
               if (map_in_range) begin
                  state <= PAINT;
               end else begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            PAINT: begin
               if (step == LAST_STEP) begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else begin
                  step <= step + 3'd1;
               end
            end
            CLEAR: begin
               canvas_q[col] <= '0;
               if (col == 5'd27) begin
                  col          <= '0;
                  busy_q       <= 1'b0;
                  clear_done_q <= 1'b1;
                  state        <= IDLE;
               end else begin
                  col <= col + 5'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.canvas     = canvas_q;
   assign bus.busy       = busy_q;
   assign bus.clear_done = clear_done_q;
endmodule
